// File: rtl/sqrt_rr_sched_if.sv
// ---------------------------------------------------------------------------
// sqrt_rr_sched_if
// Bundles every signal that moves between the round-robin sqrt scheduler,
// its requesters and the shared sqrt core.
//
// Requester side:
//   req[NREQ]        request level per requester, held until its ack
//   op_flat[NREQ*DW] operand of requester i at [i*DW +: DW]
//   ack[NREQ]        one-cycle completion pulse to the winner
//   rsp_data[RW]     result of the completed job
//   rsp_err          job aborted by the watchdog
//   busy             scheduler is not idle
//   grant_id[IW]     index of the current or last winner
// Core side:
//   core_init        one-cycle start pulse
//   core_a[DW]       operand handed to the core
//   core_done        done level from the core
//   core_result[RW]  result from the core
//
// Modports: master = the scheduler, slave = requesters plus core.
// ---------------------------------------------------------------------------
interface sqrt_rr_sched_if #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int RW   = 16
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] op_flat;
    logic [NREQ-1:0]    ack;
    logic [RW-1:0]      rsp_data;
    logic               rsp_err;
    logic               busy;
    logic [IW-1:0]      grant_id;
    logic               core_init;
    logic [DW-1:0]      core_a;
    logic               core_done;
    logic [RW-1:0]      core_result;

    modport master (
        input  req, op_flat, core_done, core_result,
        output ack, rsp_data, rsp_err, busy, grant_id, core_init, core_a
    );

    modport slave (
        output req, op_flat, core_done, core_result,
        input  ack, rsp_data, rsp_err, busy, grant_id, core_init, core_a
    );
endinterface

// File: rtl/sqrt_rr_sched.sv
// ---------------------------------------------------------------------------
// sqrt_rr_sched
// Round-robin scheduler that shares one sqrt core among NREQ requesters.
// In IDLE it picks the first pending requester starting from the round-robin
// pointer, hands its operand to the core with a one-cycle init pulse, waits
// for a rising edge of the core's done level and returns the result to the
// winner with a one-cycle ack. The pointer then moves just past the winner.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    sqrt_rr_sched_if.master (requester and core signals)
//
// Optional feature: define SQRT_SCHED_TIMEOUT_EN to build a watchdog that
// aborts a job after TMO cycles in WAIT without a done edge; the job is then
// acked with rsp_data=0 and rsp_err=1. Without it WAIT never gives up and
// rsp_err is constant 0.
// ---------------------------------------------------------------------------
module sqrt_rr_sched #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int RW   = 16,
    parameter int TMO  = 1024
) (
    input  logic           clk,
    input  logic           reset,
    sqrt_rr_sched_if.master bus
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   rrPtr_q;
    logic [IW-1:0]   grant_q;
    logic [NREQ-1:0] ack_q;
    logic [RW-1:0]   rspData_q;
    logic            busy_q;
    logic            coreInit_q;
    logic [DW-1:0]   coreA_q;
    logic            done_q;

    logic [IW-1:0]   pickIdx_d;
    logic            pickValid_d;
    logic [DW-1:0]   pickOp_d;
    logic [IW-1:0]   rrPtr_d;
    logic            doneEdge;

    // Round-robin search: walk the candidates from rrPtr_q upwards (mod NREQ)
    // and keep the first pending one. The loop runs from the far end back to
    // the pointer so that the last assignment is the closest pending slot.
    always_comb begin
        int            slot;
        logic [IW-1:0] cand;
        pickValid_d = 1'b0;
        pickIdx_d   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            slot = int'(rrPtr_q) + k;
            if (slot >= NREQ) begin
                slot = slot - NREQ;
            end
            cand = IW'(slot);
            if (bus.req[cand]) begin
                pickValid_d = 1'b1;
                pickIdx_d   = cand;
            end
        end
    end

    // Operand mux for the chosen requester; constant loop indices keep the
    // part-selects static.
    always_comb begin
        pickOp_d = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pickIdx_d == IW'(k)) begin
                pickOp_d = bus.op_flat[k*DW +: DW];
            end
        end
    end

    // Pointer moves just past the winner, wrapping NREQ-1 back to 0. A rising
    // edge of the done level is what ends a job, not the level itself.
    assign rrPtr_d  = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
    assign doneEdge = bus.core_done & ~done_q;

`ifdef SQRT_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);

    logic [CW-1:0] tmoCnt_q;
    logic          rspErr_q;

    // Main FSM with the watchdog. tmoCnt_q counts WAIT cycles from 0, so the
    // abort decision is taken in the TMO-th WAIT cycle and the ack follows.
    // done_q is reset high so a done level already high at reset release is
    // not mistaken for a completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rrPtr_q    <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            rspData_q  <= '0;
            rspErr_q   <= 1'b0;
            busy_q     <= 1'b0;
            coreInit_q <= 1'b0;
            coreA_q    <= '0;
            done_q     <= 1'b1;
            tmoCnt_q   <= '0;
        end else begin
            done_q <= bus.core_done;
            case (state_q)
                IDLE: begin
                    if (pickValid_d) begin
                        grant_q    <= pickIdx_d;
                        coreA_q    <= pickOp_d;
                        coreInit_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    coreInit_q <= 1'b0;
                    tmoCnt_q   <= '0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (doneEdge) begin
                        rspData_q <= bus.core_result;
                        ack_q     <= NREQ'(1) << grant_q;
                        state_q   <= DONE;
                    end else if (tmoCnt_q == CW'(TMO - 1)) begin
                        rspData_q <= '0;
                        rspErr_q  <= 1'b1;
                        ack_q     <= NREQ'(1) << grant_q;
                        state_q   <= DONE;
                    end else begin
                        tmoCnt_q <= tmoCnt_q + 1'b1;
                    end
                end
                DONE: begin
                    ack_q    <= '0;
                    rspErr_q <= 1'b0;
                    rrPtr_q  <= rrPtr_d;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_err = rspErr_q;
`else
    // Main FSM without the watchdog: WAIT only leaves on a done edge. done_q
    // is reset high so a done level already high at reset release is not
    // mistaken for a completion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rrPtr_q    <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            rspData_q  <= '0;
            busy_q     <= 1'b0;
            coreInit_q <= 1'b0;
            coreA_q    <= '0;
            done_q     <= 1'b1;
        end else begin
            done_q <= bus.core_done;
            case (state_q)
                IDLE: begin
                    if (pickValid_d) begin
                        grant_q    <= pickIdx_d;
                        coreA_q    <= pickOp_d;
                        coreInit_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    coreInit_q <= 1'b0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (doneEdge) begin
                        rspData_q <= bus.core_result;
                        ack_q     <= NREQ'(1) << grant_q;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    ack_q   <= '0;
                    rrPtr_q <= rrPtr_d;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // No watchdog is built, so no job can abort; the expression is constant
    // zero for any legal TMO and only keeps the parameter referenced.
    assign bus.rsp_err = (TMO < 0);
`endif

    assign bus.ack       = ack_q;
    assign bus.rsp_data  = rspData_q;
    assign bus.busy      = busy_q;
    assign bus.grant_id  = grant_q;
    assign bus.core_init = coreInit_q;
    assign bus.core_a    = coreA_q;
endmodule

// File: tb/tb_sqrt_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_sqrt_rr_sched
// Bench for sqrt_rr_sched with NREQ=4, DW=RW=16, TMO=16. A behavioural sqrt
// core answers each init after a random latency. A transaction-level model
// predicts the winner of each arbitration from the request vector and a
// round-robin pointer, the result from an integer square root, and the cycle
// in which each ack must appear.
// ---------------------------------------------------------------------------
module tb_sqrt_rr_sched;
    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int RW   = 16;
    localparam int TMO  = 16;

    typedef logic [1:0] idx_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    sqrt_rr_sched_if #(.NREQ(NREQ), .DW(DW), .RW(RW)) bus ();

    sqrt_rr_sched #(.NREQ(NREQ), .DW(DW), .RW(RW), .TMO(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [NREQ-1:0] reqV;
    logic [DW-1:0]   opV [NREQ];

    // Requester pins follow the bench's request/operand variables.
    always_comb begin
        bus.req = reqV;
        for (int i = 0; i < NREQ; i++) begin
            bus.op_flat[i*DW +: DW] = opV[i];
        end
    end

    int compared = 0;
    int failed   = 0;

    idx_t            modelPtr;
    idx_t            winner;
    logic [DW-1:0]   winOp;
    bit              outstanding;
    bit              ackDue;
    bit              expErr;
    bit              prevIdle;
    bit              modelIdle;
    bit              idleFromNext;
    bit [NREQ-1:0]   granted;
    bit [NREQ-1:0]   resubMask;
    bit              randomMode;
    bit              coreNever;
    int              coreLat;
    int              waitCycles;
    int              cycleNo;
    int              initCycle;
    int              ackCycle;
    int              ackLog [$];
    int              rspLog [$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cycleNo);
        end
    endtask

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic idx_t rrPick(input idx_t ptr, input logic [NREQ-1:0] r);
        idx_t cand;
        for (int k = 0; k < NREQ; k++) begin
            cand = idx_t'((int'(ptr) + k) % NREQ);
            if (r[cand]) return cand;
        end
        return ptr;
    endfunction

    function automatic logic [DW-1:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h0001;
            default: return DW'($urandom);
        endcase
    endfunction

    // Random requester behaviour: idle requesters raise req with a fresh
    // operand, pending ones occasionally give up, granted ones may drop req.
    task automatic applyStimulus();
        logic [NREQ-1:0] b;
        for (int i = 0; i < NREQ; i++) begin
            b = NREQ'(1) << i;
            if ((granted & b) != 0) begin
                if ($urandom_range(0, 7) == 0) reqV = reqV & ~b;
            end else if ((reqV & b) == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    reqV = reqV | b;
                    opV[idx_t'(i)] = pickOperand();
                end
            end else if ($urandom_range(0, 19) == 0) begin
                reqV = reqV & ~b;
            end
        end
    endtask

    // One clock cycle: sample just after the rising edge, compare against
    // the model, step the core model, then drive the next requests.
    task automatic runCycle();
        logic [NREQ-1:0] reqPrev;
        logic [DW-1:0]   opPrev [NREQ];
        bit              expInit;
        idx_t            w;
        @(posedge clk);
        #1;
        cycleNo++;
        reqPrev = reqV;
        for (int i = 0; i < NREQ; i++) opPrev[i] = opV[i];
        expInit = prevIdle && (reqPrev != 0);
        if (idleFromNext) begin
            modelIdle    = 1'b1;
            idleFromNext = 1'b0;
        end

        checkOutput("ack", 32'(bus.ack), ackDue ? (32'(1) << winner) : 32'(0));
        if (ackDue) begin
            checkOutput("rspData", 32'(bus.rsp_data), expErr ? 32'(0) : 32'(isqrt(int'(winOp))));
            checkOutput("rspErr", 32'(bus.rsp_err), 32'(expErr));
            ackLog.push_back(int'(winner));
            rspLog.push_back(int'(bus.rsp_data));
            ackCycle     = cycleNo;
            modelPtr     = idx_t'((int'(winner) + 1) % NREQ);
            outstanding  = 1'b0;
            ackDue       = 1'b0;
            expErr       = 1'b0;
            idleFromNext = 1'b1;
            granted      = granted & ~(NREQ'(1) << winner);
            reqV         = reqV & ~(NREQ'(1) << winner);
            if (resubMask[winner]) begin
                reqV = reqV | (NREQ'(1) << winner);
                opV[winner] = pickOperand();
            end
        end else begin
            checkOutput("rspErrIdle", 32'(bus.rsp_err), 32'(0));
        end

        checkOutput("coreInit", 32'(bus.core_init), 32'(expInit));
        if (expInit) begin
            w = rrPick(modelPtr, reqPrev);
            checkOutput("grantId", 32'(bus.grant_id), 32'(w));
            checkOutput("coreA", 32'(bus.core_a), 32'(opPrev[w]));
            outstanding = 1'b1;
            winner      = w;
            winOp       = opPrev[w];
            granted     = granted | (NREQ'(1) << w);
            modelIdle   = 1'b0;
            bus.core_done = 1'b0;
            coreLat     = coreNever ? -1 : int'($urandom_range(1, 6));
            waitCycles  = 0;
            initCycle   = cycleNo;
        end else if (outstanding && !ackDue) begin
            waitCycles++;
            if (coreLat > 0) begin
                coreLat--;
                if (coreLat == 0) begin
                    bus.core_done   = 1'b1;
                    bus.core_result = RW'(isqrt(int'(bus.core_a)));
                    coreLat = -1;
                    ackDue  = 1'b1;
                end
            end
`ifdef SQRT_SCHED_TIMEOUT_EN
            if (!ackDue && waitCycles == TMO) begin
                ackDue = 1'b1;
                expErr = 1'b1;
            end
`endif
        end

        checkOutput("busy", 32'(bus.busy), 32'(!modelIdle));
        if (randomMode) applyStimulus();
        prevIdle = modelIdle;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        checkOutput("rstAck", 32'(bus.ack), 32'(0));
        checkOutput("rstRspData", 32'(bus.rsp_data), 32'(0));
        checkOutput("rstRspErr", 32'(bus.rsp_err), 32'(0));
        checkOutput("rstBusy", 32'(bus.busy), 32'(0));
        checkOutput("rstGrantId", 32'(bus.grant_id), 32'(0));
        checkOutput("rstCoreInit", 32'(bus.core_init), 32'(0));
        checkOutput("rstCoreA", 32'(bus.core_a), 32'(0));
        reqV         = '0;
        modelPtr     = '0;
        outstanding  = 1'b0;
        ackDue       = 1'b0;
        expErr       = 1'b0;
        prevIdle     = 1'b1;
        modelIdle    = 1'b1;
        idleFromNext = 1'b0;
        granted      = '0;
        coreLat      = -1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic runUntilAcks(input int target, input int budget);
        int n = 0;
        while (ackLog.size() < target && n < budget) begin
            runCycle();
            n++;
        end
        checkOutput("ackBudget", 32'(ackLog.size()), 32'(target));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int b;
        reqV            = '0;
        for (int i = 0; i < NREQ; i++) opV[i] = '0;
        bus.core_done   = 1'b1;
        bus.core_result = '0;
        cycleNo         = 0;
        randomMode      = 1'b0;
        coreNever       = 1'b0;
        resubMask       = '0;

        // Single job
        doReset();
        b = ackLog.size();
        reqV = 4'b0001;
        opV[0] = 16'h0441;
        runUntilAcks(b + 1, 40);
        if (rspLog.size() > b) checkOutput("t1Result", 32'(rspLog[b]), 32'h21);

        // Contention after reset: served 0,1,2,3
        doReset();
        b = ackLog.size();
        opV[0] = 16'h0100;
        opV[1] = 16'h0441;
        opV[2] = 16'hFFFF;
        opV[3] = 16'h0000;
        reqV = 4'b1111;
        runUntilAcks(b + 4, 120);
        if (ackLog.size() >= b + 4) begin
            for (int i = 0; i < 4; i++) checkOutput("t2Order", 32'(ackLog[b+i]), 32'(i));
            checkOutput("t2Res0", 32'(rspLog[b]),   32'h10);
            checkOutput("t2Res1", 32'(rspLog[b+1]), 32'h21);
            checkOutput("t2Res2", 32'(rspLog[b+2]), 32'hFF);
            checkOutput("t2Res3", 32'(rspLog[b+3]), 32'h00);
        end

        // Fairness between two continuously resubmitting requesters
        b = ackLog.size();
        resubMask = 4'b0110;
        opV[1] = pickOperand();
        opV[2] = pickOperand();
        reqV = 4'b0110;
        runUntilAcks(b + 4, 120);
        resubMask = '0;
        if (ackLog.size() >= b + 4) begin
            checkOutput("t3First", 32'(ackLog[b]), 32'(1));
            for (int i = 1; i < 4; i++) checkOutput("t3Alternate", 32'(ackLog[b+i] == ackLog[b+i-1]), 32'(0));
        end

        // Wrap: serve 2 alone, then 1001 must go 3 then 0
        doReset();
        b = ackLog.size();
        opV[2] = pickOperand();
        reqV = 4'b0100;
        runUntilAcks(b + 1, 40);
        opV[0] = pickOperand();
        opV[3] = pickOperand();
        reqV = 4'b1001;
        runUntilAcks(b + 3, 80);
        if (ackLog.size() >= b + 3) begin
            checkOutput("t4First", 32'(ackLog[b+1]), 32'(3));
            checkOutput("t4Second", 32'(ackLog[b+2]), 32'(0));
        end

        // Reset in WAIT, then a stray done edge in IDLE must not ack
        coreNever = 1'b1;
        opV[1] = 16'h1234;
        reqV = 4'b0010;
        repeat (6) runCycle();
        doReset();
        coreNever = 1'b0;
        b = ackLog.size();
        repeat (2) runCycle();
        bus.core_done   = 1'b1;
        bus.core_result = 16'h00AA;
        repeat (5) runCycle();
        checkOutput("t5NoAck", 32'(ackLog.size()), 32'(b));
        opV[0] = 16'h0441;
        reqV = 4'b0001;
        runUntilAcks(b + 1, 40);
        if (rspLog.size() > b) checkOutput("t5Result", 32'(rspLog[b]), 32'h21);

        // Core that never finishes
        coreNever = 1'b1;
        b = ackLog.size();
        opV[2] = 16'h0441;
        reqV = 4'b0100;
`ifdef SQRT_SCHED_TIMEOUT_EN
        runUntilAcks(b + 1, 60);
        if (ackLog.size() > b) begin
            checkOutput("t6Latency", 32'(ackCycle - initCycle), 32'(17));
            checkOutput("t6Data", 32'(rspLog[b]), 32'(0));
        end
`else
        repeat (40) runCycle();
        checkOutput("t6BusyHeld", 32'(bus.busy), 32'(1));
        checkOutput("t6NoAck", 32'(ackLog.size()), 32'(b));
`endif
        coreNever = 1'b0;

        // Randomised traffic
        doReset();
        b = ackLog.size();
        randomMode = 1'b1;
        repeat (1500) runCycle();
        randomMode = 1'b0;
        checkOutput("randJobs", 32'(ackLog.size() - b >= 50), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
